ripple_carry_adder: RTL and testbench

Parameterised ripple-carry adder built as a chain of 1-bit full-adder stages, with registered outputs. It adds two WIDTH-bit operands and a carry-in. It exposes the sum and the carry-out of every stage; the MSB of the stage carries is the overall carry-out. It serves as a small arithmetic leaf in datapaths that need per-stage carry visibility, for example overflow and debug observation.

---
 rtl/rca_pkg.sv | 27 ++
 rtl/ripple_carry_adder_full_adder.sv | 20 ++
 rtl/ripple_carry_adder.sv | 60 ++++++
 tb/tb_ripple_carry_adder.sv | 165 ++++++++++++++++
 4 files changed

// File: rtl/rca_pkg.sv
// Shared definitions for the ripple-carry adder slice.
// - RCA_DEFAULT_WIDTH : default operand width.
// - RCA_MAX_WIDTH     : widest operand rca_ref_sum can model.
// - rca_ref_sum()     : reference A + B + Cin. The result is truncated to
//                       width+1 bits, for use in benches and assertions.
package rca_pkg;

  localparam int unsigned RCA_DEFAULT_WIDTH = 4;
  localparam int unsigned RCA_MAX_WIDTH     = 64;

  // Operands are passed zero-extended to RCA_MAX_WIDTH. Result bits above
  // position `width` are cleared, so bit [width] is the final carry.
  function automatic logic [RCA_MAX_WIDTH:0] rca_ref_sum(
    input logic [RCA_MAX_WIDTH-1:0] a,
    input logic [RCA_MAX_WIDTH-1:0] b,
    input logic                     cin,
    input int unsigned              width
  );
    logic [RCA_MAX_WIDTH:0] r;
    r = {1'b0, a} + {1'b0, b} + {{RCA_MAX_WIDTH{1'b0}}, cin};
    for (int unsigned i = 0; i <= RCA_MAX_WIDTH; i++) begin
      if (i > width) r[i] = 1'b0;
    end
    return r;
  endfunction

endpackage

// File: rtl/ripple_carry_adder_full_adder.sv
// One-bit full adder stage of the ripple-carry chain. Purely combinational.
// Ports:
//   a, b : operand bits
//   ci   : carry in from the previous stage (or Cin for stage 0)
//   s    : sum bit
//   co   : carry out to the next stage
module full_adder (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  always_comb begin
    s  = a ^ b ^ ci;
    co = (a & b) | (a & ci) | (b & ci);
  end

endmodule

// File: rtl/ripple_carry_adder.sv
// Parameterised ripple-carry adder with registered outputs.
// A chain of WIDTH full_adder stages computes A + B + Cin. The sum and the
// carry out of every stage are captured on an accepted input.
// Ports:
//   clk       : system clock, rising-edge active
//   rst_n     : synchronous reset, active low (takes priority over in_valid)
//   A, B      : WIDTH-bit unsigned operands
//   Cin       : carry into stage 0
//   in_valid  : qualifies A/B/Cin for capture
//   S         : registered sum
//   Cout      : registered per-stage carries; Cout[WIDTH-1] is the final carry
//   out_valid : high for the one cycle after an accepted input
module ripple_carry_adder
  import rca_pkg::*;
#(
  parameter int unsigned WIDTH = RCA_DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  input  logic             in_valid,
  output logic [WIDTH-1:0] S,
  output logic [WIDTH-1:0] Cout,
  output logic             out_valid
);

  // c[i] is the carry into stage i, and c[i+1] is the carry out of it.
  // c[0] is Cin, which keeps the chain indexing uniform.
  logic [WIDTH:0]   c;
  logic [WIDTH-1:0] s_core;

  assign c[0] = Cin;

  for (genvar i = 0; i < WIDTH; i++) begin : g_stage
    full_adder u_fa (
      .a  (A[i]),
      .b  (B[i]),
      .ci (c[i]),
      .s  (s_core[i]),
      .co (c[i+1])
    );
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      S         <= '0;
      Cout      <= '0;
      out_valid <= 1'b0;
    end else if (in_valid) begin
      S         <= s_core;
      Cout      <= c[WIDTH:1];
      out_valid <= 1'b1;
    end else begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_ripple_carry_adder.sv
// Directed and random checks for ripple_carry_adder at WIDTH=4.
module tb_ripple_carry_adder;
  import rca_pkg::*;

  localparam int unsigned W = 4;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [W-1:0] A, B;
  logic         Cin;
  logic         in_valid;
  logic [W-1:0] S;
  logic [W-1:0] Cout;
  logic         out_valid;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  ripple_carry_adder #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .A         (A),
    .B         (B),
    .Cin       (Cin),
    .in_valid  (in_valid),
    .S         (S),
    .Cout      (Cout),
    .out_valid (out_valid)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic [W-1:0] exp_s;
    logic [W-1:0] exp_c;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Per-stage carry chain from the bit-level recurrence.
  function automatic logic [W-1:0] ref_carries(input logic [W-1:0] a, input logic [W-1:0] b,
                                               input logic cin);
    logic         c;
    logic [W-1:0] r;
    c = cin;
    for (int i = 0; i < int'(W); i++) begin
      c    = (a[i] & b[i]) | (a[i] & c) | (b[i] & c);
      r[i] = c;
    end
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [RCA_MAX_WIDTH:0] ref_full;
    logic [W-1:0]           m_s, m_c;
    logic                   m_v;
    logic                   do_rst;

    vecs[0] = '{4'h1, 4'h0, 1'b0, 4'b0001, 4'b0000};
    vecs[1] = '{4'h2, 4'h4, 1'b1, 4'b0111, 4'b0000};
    vecs[2] = '{4'hB, 4'h6, 1'b0, 4'b0001, 4'b1110};
    vecs[3] = '{4'hF, 4'hF, 1'b1, 4'b1111, 4'b1111};
    vecs[4] = '{4'h0, 4'h0, 1'b0, 4'b0000, 4'b0000};
    vecs[5] = '{4'h8, 4'h8, 1'b0, 4'b0000, 4'b1000};
    vecs[6] = '{4'hF, 4'h0, 1'b1, 4'b0000, 4'b1111};
    vecs[7] = '{4'h5, 4'h3, 1'b1, 4'b1001, 4'b0111};

    // Reset held with a live input: nothing may be captured.
    rst_n = 1'b0; in_valid = 1'b1; A = 4'hF; B = 4'hF; Cin = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      chk("rst_S", 32'(S), 32'h0);
      chk("rst_Cout", 32'(Cout), 32'h0);
      chk("rst_valid", 32'(out_valid), 32'h0);
    end
    rst_n = 1'b1; in_valid = 1'b0;
    tick();
    chk("idle_valid", 32'(out_valid), 32'h0);
    chk("idle_S", 32'(S), 32'h0);

    // Back-to-back table vectors.
    for (int k = 0; k < 8; k++) begin
      A = vecs[k].a; B = vecs[k].b; Cin = vecs[k].cin; in_valid = 1'b1;
      tick();
      chk($sformatf("vec%0d_S", k), 32'(S), 32'(vecs[k].exp_s));
      chk($sformatf("vec%0d_Cout", k), 32'(Cout), 32'(vecs[k].exp_c));
      chk($sformatf("vec%0d_valid", k), 32'(out_valid), 32'h1);
    end

    // No capture: outputs hold the 5+3+1 result while inputs change.
    in_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      A = 4'(i + 9); B = 4'(i * 3); Cin = i[0];
      tick();
      chk("hold_S", 32'(S), 32'h9);
      chk("hold_Cout", 32'(Cout), 32'h7);
      chk("hold_valid", 32'(out_valid), 32'h0);
    end

    // Reset on the same edge as a valid input discards that input.
    A = 4'h7; B = 4'h7; Cin = 1'b0; in_valid = 1'b1; rst_n = 1'b0;
    tick();
    chk("midrst_S", 32'(S), 32'h0);
    chk("midrst_Cout", 32'(Cout), 32'h0);
    chk("midrst_valid", 32'(out_valid), 32'h0);
    rst_n = 1'b1; in_valid = 1'b0;
    tick();
    chk("postrst_valid", 32'(out_valid), 32'h0);
    A = 4'h1; B = 4'h1; Cin = 1'b0; in_valid = 1'b1;
    tick();
    chk("postrst_first_S", 32'(S), 32'h2);
    chk("postrst_first_Cout", 32'(Cout), 32'h1);
    chk("postrst_first_valid", 32'(out_valid), 32'h1);

    // Random stream with gaps and one reset pulse.
    m_s = S; m_c = Cout;
    for (int n = 0; n < 1000; n++) begin
      A = 4'($urandom_range(0, 15));
      B = 4'($urandom_range(0, 15));
      Cin = 1'($urandom_range(0, 1));
      in_valid = ($urandom_range(0, 9) < 7);
      do_rst = (n == 500);
      rst_n = !do_rst;
      if (do_rst) begin
        m_s = '0; m_c = '0; m_v = 1'b0;
      end else if (in_valid) begin
        ref_full = rca_ref_sum(RCA_MAX_WIDTH'(A), RCA_MAX_WIDTH'(B), Cin, W);
        m_s = ref_full[W-1:0];
        m_c = ref_carries(A, B, Cin);
        m_v = 1'b1;
        if (m_c[W-1] != ref_full[W]) begin
          n_cmp++; n_bad++;
          $display("FAIL model_carry: recurrence %0d vs arithmetic %0d", m_c[W-1], ref_full[W]);
        end
      end else begin
        m_v = 1'b0;
      end
      tick();
      chk("rnd_valid", 32'(out_valid), 32'(m_v));
      chk("rnd_S", 32'(S), 32'(m_s));
      chk("rnd_Cout", 32'(Cout), 32'(m_c));
    end
    rst_n = 1'b1; in_valid = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
